regfile_sb: RTL and testbench

Parametrised successor to the 16x32 general-purpose register file.
- Configurable data width and register count; two combinational read ports, one write port.
- Per-register scoreboard (pending bits) so multicycle units can reserve a destination.
- Same-cycle write-to-read bypass; sequential bulk-clear engine; sticky address-error flag.
- Sits between decode (read and reserve addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 41 ++++
 rtl/regfile_sb.sv | 144 ++++++++++++++
 tb/tb_regfile_sb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the regfile_sb register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_NUM_REGS = 16;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_CLEARING = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: decode reserves a destination, writeback releases it,
// and the clear engine wipes one entry per cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_en,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             rel_en,
    input  logic [IDX_W-1:0] rel_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] look1_idx,
    input  logic [IDX_W-1:0] look2_idx,
    output logic             pend1,
    output logic             pend2
);

    logic [NUM_REGS-1:0] pending;

    // NOTE: non-blocking assignments; the later reserve overrides an earlier release of
    // the same bit in this cycle, so a newer producer keeps the register pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (clr_en) begin
            pending[clr_idx] <= 1'b0;
        end else begin
            if (rel_en) pending[rel_idx] <= 1'b0;
            if (res_en) pending[res_idx] <= 1'b1;
        end
    end

    assign pend1 = pending[look1_idx];
    assign pend2 = pending[look2_idx];

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with scoreboard, write-to-read bypass and sequential clear.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] Raddr1,
    input  logic [ADDR_W-1:0] Raddr2,
    output logic [DATA_W-1:0] Read1,
    output logic [DATA_W-1:0] Read2,
    output logic              Rvalid1,
    output logic              Rvalid2,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic [DATA_W-1:0] Writedata,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] Resaddr,
    input  logic              RegRes,
    input  logic              Clear,
    output logic              Busy,
    output logic              AddrErr
);

    localparam int                IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              idle;
    logic              wr_ok;
    logic              res_ok;
    logic              bad_addr;
    logic              pend1;
    logic              pend2;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Returns {valid, data} for one read port.
    function automatic logic [DATA_W:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              pend,
        input logic              idle_now,
        input logic              wr,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        // NOTE: every path assigns r before use, so no latch can be inferred.
        logic [DATA_W:0] r;
        r = {1'b1, {DATA_W{1'b0}}};
        if (!in_range(a) || is_zero_reg(a)) r = {1'b1, {DATA_W{1'b0}}};
        else if (idle_now && wr && wa == a) r = {1'b1, wd};
        else                                r = {!pend, stored};
        if (!idle_now) r[DATA_W] = 1'b0;
        return r;
    endfunction

    assign idle     = (state == ST_IDLE);
    assign Busy     = (state == ST_CLEARING);
    assign wr_ok    = idle && RegWr && in_range(Waddr) && !is_zero_reg(Waddr);
    assign res_ok   = idle && RegRes && in_range(Resaddr) && !is_zero_reg(Resaddr);
    assign bad_addr = idle && ((RegWr && !in_range(Waddr)) || (RegRes && !in_range(Resaddr)));

    always_comb begin
        {Rvalid1, Read1} = read_port(Raddr1, regs[Raddr1[IDX_W-1:0]], pend1,
                                     idle, RegWr, Waddr, Writedata);
        {Rvalid2, Read2} = read_port(Raddr2, regs[Raddr2[IDX_W-1:0]], pend2,
                                     idle, RegWr, Waddr, Writedata);
    end

    // NOTE: the array is reset deliberately: reset must leave every register reading zero,
    // so this stays in flops rather than a RAM macro.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (!idle) begin
            regs[cnt[IDX_W-1:0]] <= '0;
        end else if (wr_ok) begin
            regs[Waddr[IDX_W-1:0]] <= Writedata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Clear) begin
                        state <= ST_CLEARING;
                        cnt   <= '0;
                    end
                end
                ST_CLEARING: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)         AddrErr <= 1'b0;
        else if (bad_addr) AddrErr <= 1'b1;
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk       (CLK),
        .reset     (RESET),
        .res_en    (res_ok),
        .res_idx   (Resaddr[IDX_W-1:0]),
        .rel_en    (wr_ok),
        .rel_idx   (Waddr[IDX_W-1:0]),
        .clr_en    (!idle),
        .clr_idx   (cnt[IDX_W-1:0]),
        .look1_idx (Raddr1[IDX_W-1:0]),
        .look2_idx (Raddr2[IDX_W-1:0]),
        .pend1     (pend1),
        .pend2     (pend2)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: read expectations go through a cycle-stamped queue,
// control flags are compared inline by each scenario task.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 16;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [AW-1:0] Raddr1 = '0, Raddr2 = '0, Waddr = '0, Resaddr = '0;
    logic [DW-1:0] Read1, Read2, Writedata = '0;
    logic          Rvalid1, Rvalid2;
    logic          RegWr = 1'b0, RegRes = 1'b0, Clear = 1'b0;
    logic          Busy, AddrErr;

    typedef struct {
        int            cyc;
        int            port;
        logic [DW-1:0] data;
        logic          valid;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .CLK(CLK), .RESET(RESET),
        .Raddr1(Raddr1), .Raddr2(Raddr2),
        .Read1(Read1), .Read2(Read2),
        .Rvalid1(Rvalid1), .Rvalid2(Rvalid2),
        .Waddr(Waddr), .Writedata(Writedata), .RegWr(RegWr),
        .Resaddr(Resaddr), .RegRes(RegRes),
        .Clear(Clear), .Busy(Busy), .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Reads are combinational: expectations stamped with this cycle are checked mid-cycle.
    always @(negedge CLK) begin : monitor
        exp_t          e;
        logic [DW-1:0] act_d;
        logic          act_v;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            act_d = (e.port == 1) ? Read1 : Read2;
            act_v = (e.port == 1) ? Rvalid1 : Rvalid2;
            vectors++;
            if (act_d !== e.data || act_v !== e.valid) begin
                miscompares++;
                $display("FAIL %s: port%0d data=%h valid=%b, required data=%h valid=%b",
                         e.name, e.port, act_d, act_v, e.data, e.valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_rd(input int port, input logic [DW-1:0] data, input logic valid,
                             input string name);
        exp_t e;
        e.cyc = cyc; e.port = port; e.data = data; e.valid = valid; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        RegWr = 1'b0; RegRes = 1'b0; Clear = 1'b0;
        Waddr = '0; Resaddr = '0; Writedata = '0;
    endtask

    function automatic logic [DW-1:0] r0_val(input logic [DW-1:0] v);
        return ZERO_REG ? '0 : v;
    endfunction

    task automatic flag_check(input logic act, input logic req, input string name);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < NR; i++) begin
            Raddr1 = AW'(i);
            expect_rd(1, '0, 1'b1, $sformatf("%s r%0d", tag, i));
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        flag_check(Busy, 1'b0, "reset Busy");
        flag_check(AddrErr, 1'b0, "reset AddrErr");
        for (int a = 0; a < 32; a++) begin
            Raddr1 = AW'(a);
            Raddr2 = AW'(31 - a);
            expect_rd(1, '0, 1'b1, $sformatf("reset read1 a%0d", a));
            expect_rd(2, '0, 1'b1, $sformatf("reset read2 a%0d", 31 - a));
            tick();
        end
    endtask

    task automatic test_write_bypass();
        idle_inputs();
        RegWr = 1'b1; Waddr = 5'd3; Writedata = 32'h0000_00AA; Raddr1 = 5'd3;
        expect_rd(1, 32'hAA, 1'b1, "r3 bypass");
        tick();
        RegWr = 1'b0;
        expect_rd(1, 32'hAA, 1'b1, "r3 stored");
        tick();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        Raddr2 = 5'd5;
        RegRes = 1'b1; Resaddr = 5'd5;
        expect_rd(2, '0, 1'b1, "r5 before reserve");
        tick();
        RegRes = 1'b0;
        expect_rd(2, '0, 1'b0, "r5 pending");
        tick();
        RegWr = 1'b1; Waddr = 5'd5; Writedata = 32'd7;
        expect_rd(2, 32'd7, 1'b1, "r5 write bypass");
        tick();
        RegWr = 1'b0;
        expect_rd(2, 32'd7, 1'b1, "r5 released");
        tick();
        RegWr = 1'b1; RegRes = 1'b1; Writedata = 32'd9;
        expect_rd(2, 32'd9, 1'b1, "r5 res+wr bypass");
        tick();
        RegWr = 1'b0; RegRes = 1'b0;
        expect_rd(2, 32'd9, 1'b0, "r5 reserve wins");
        tick();
        RegRes = 1'b1;
        expect_rd(2, 32'd9, 1'b0, "r5 double reserve");
        tick();
        RegRes = 1'b0; RegWr = 1'b1; Writedata = 32'd10;
        expect_rd(2, 32'd10, 1'b1, "r5 release bypass");
        tick();
        RegWr = 1'b0; Raddr1 = 5'd3;
        expect_rd(2, 32'd10, 1'b1, "r5 single release");
        expect_rd(1, 32'hAA, 1'b1, "r3 untouched");
        tick();
    endtask

    task automatic test_clear();
        int n;
        idle_inputs();
        for (int i = 0; i < NR; i++) begin
            RegWr = 1'b1; Waddr = AW'(i); Writedata = DW'(i + 1);
            tick();
        end
        RegWr = 1'b0; RegRes = 1'b1; Resaddr = 5'd2;
        tick();
        RegRes = 1'b0;
        for (int i = 0; i < NR; i++) begin
            Raddr1 = AW'(i);
            expect_rd(1, (i == 0) ? r0_val(32'd1) : DW'(i + 1), (i == 2) ? 1'b0 : 1'b1,
                      $sformatf("fill r%0d", i));
            tick();
        end
        Clear = 1'b1; RegWr = 1'b1; Waddr = 5'd0; Writedata = 32'h77;
        Raddr2 = 5'd0;
        expect_rd(2, r0_val(32'h77), 1'b1, "clear-cycle write bypass");
        tick();
        n = 0;
        while (Busy && n < 100) begin
            Clear = (n < 3);
            RegWr = 1'b1; Writedata = 32'hFF;
            Waddr = (n % 2 == 1) ? 5'd20 : AW'(n % NR);
            RegRes = 1'b1; Resaddr = 5'd21;
            Raddr1 = 5'd15;
            Raddr2 = (n == 0) ? 5'd0 : 5'd20;
            expect_rd(1, 32'd16, 1'b0, $sformatf("busy r15 n%0d", n));
            expect_rd(2, (n == 0) ? r0_val(32'h77) : '0, 1'b0, $sformatf("busy port2 n%0d", n));
            n++;
            tick();
        end
        idle_inputs();
        vectors++;
        if (n != NR) begin
            miscompares++;
            $display("FAIL busy length: got %0d cycles, required %0d", n, NR);
        end
        flag_check(AddrErr, 1'b0, "no AddrErr from busy writes");
        read_all_zero("after clear");
    endtask

    task automatic test_addr_err();
        idle_inputs();
        RegWr = 1'b1; Waddr = 5'd20; Writedata = 32'hDEAD;
        Raddr1 = 5'd20; Raddr2 = 5'd4;
        expect_rd(1, '0, 1'b1, "r20 read during bad write");
        expect_rd(2, '0, 1'b1, "r4 during bad write");
        flag_check(AddrErr, 1'b0, "AddrErr before edge");
        tick();
        RegWr = 1'b0;
        flag_check(AddrErr, 1'b1, "AddrErr set");
        expect_rd(1, '0, 1'b1, "r20 after bad write");
        expect_rd(2, '0, 1'b1, "r4 not aliased");
        tick();
        RegRes = 1'b1; Resaddr = 5'd31;
        tick();
        RegRes = 1'b0;
        repeat (3) tick();
        flag_check(AddrErr, 1'b1, "AddrErr sticky");
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        RegWr = 1'b1; Waddr = 5'd7; Writedata = 32'h77;
        tick();
        Waddr = 5'd1; Writedata = 32'h11;
        tick();
        RegWr = 1'b0; RegRes = 1'b1; Resaddr = 5'd9;
        tick();
        RegRes = 1'b0; Clear = 1'b1;
        tick();
        Clear = 1'b0;
        repeat (4) tick();
        flag_check(Busy, 1'b1, "busy in 5th clear cycle");
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        flag_check(Busy, 1'b0, "Busy after mid-clear reset");
        flag_check(AddrErr, 1'b0, "AddrErr after reset");
        read_all_zero("mid-clear reset");
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        RegWr = 1'b1; Waddr = 5'd0; Writedata = 32'h55; Raddr1 = 5'd0;
        expect_rd(1, r0_val(32'h55), 1'b1, "r0 write bypass");
        tick();
        RegWr = 1'b0;
        expect_rd(1, r0_val(32'h55), 1'b1, "r0 stored");
        flag_check(AddrErr, 1'b0, "r0 write AddrErr");
        tick();
        RegRes = 1'b1; Resaddr = 5'd0;
        tick();
        RegRes = 1'b0;
        expect_rd(1, r0_val(32'h55), ZERO_REG ? 1'b1 : 1'b0, "r0 after reserve");
        flag_check(AddrErr, 1'b0, "r0 reserve AddrErr");
        tick();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_clear();
        test_addr_err();
        test_reset_mid_clear();
        test_zero_reg();
        tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
